// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter
//   Two request ports share one combinational IEEE-754 single-precision
//   add/sub core. A three-state FSM (IDLE -> EXEC -> RESP) grants one port
//   at a time, round-robin when both ports request in the same cycle.
//   Operands are captured on the grant. The core result is registered in
//   EXEC and held in RESP until the response handshake completes.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake for port N (N = 0, 1);
//                            ready is combinational and only high in IDLE
//   reqN_a, reqN_b, reqN_sub operands and add(0)/subtract(1) select
//   rsp_valid/ready          response handshake
//   rsp_id                   index of the port that issued this response
//   rsp_result, rsp_exc,     core result word and flags, passed through
//   rsp_ovf, rsp_unf
//   busy                     high whenever the FSM is not in IDLE
//   cnt0, cnt1               saturating counts of completed operations

// add_sub: combinational single-precision adder/subtractor.
//   Rounding is round-to-nearest-even. Denormal inputs are flushed to zero.
//   If either operand is Inf/NaN, exception is set and the result is all ones.
//   On overflow, overflow is set and the result is a signed infinity.
//   On underflow, underflow is set and the result is a signed zero.
module add_sub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow,
  output logic        underflow
);
  logic        sign_a, sign_b, sign_l, sign_s, swap, lz_found, round_up;
  logic [30:0] mag_a, mag_b;
  logic [23:0] man_a, man_b, man_l, man_s;
  logic [7:0]  exp_l, exp_s, exp_diff;
  logic [4:0]  shamt, lz;
  logic [53:0] shift_buf;
  logic [26:0] small_sh, norm;
  logic [27:0] sum;
  logic [9:0]  exp_n;
  logic [24:0] rnd;
  logic [22:0] frac;

  always_comb begin
    sign_a = a[31];
    sign_b = b[31] ^ sub;
    mag_a  = (a[30:23] == 8'd0) ? 31'd0 : a[30:0];
    mag_b  = (b[30:23] == 8'd0) ? 31'd0 : b[30:0];
    man_a  = (mag_a == 31'd0) ? 24'd0 : {1'b1, mag_a[22:0]};
    man_b  = (mag_b == 31'd0) ? 24'd0 : {1'b1, mag_b[22:0]};

    // Order operands by magnitude so the aligned subtraction is never negative.
    swap   = mag_b > mag_a;
    sign_l = swap ? sign_b : sign_a;
    sign_s = swap ? sign_a : sign_b;
    exp_l  = swap ? mag_b[30:23] : mag_a[30:23];
    exp_s  = swap ? mag_a[30:23] : mag_b[30:23];
    man_l  = swap ? man_b : man_a;
    man_s  = swap ? man_a : man_b;

    // Align the smaller operand. Three extra low bits hold guard, round and
    // sticky. Bits shifted out of the window fold into the sticky bit.
    exp_diff  = exp_l - exp_s;
    shamt     = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
    shift_buf = {man_s, 3'b000, 27'd0} >> shamt;
    small_sh  = {shift_buf[53:28], shift_buf[27] | (|shift_buf[26:0])};

    if (sign_l == sign_s) sum = {1'b0, man_l, 3'b000} + {1'b0, small_sh};
    else                  sum = {1'b0, man_l, 3'b000} - {1'b0, small_sh};

    // Normalize: a carry-out shifts right one place, otherwise remove leading zeros.
    exp_n    = {2'b00, exp_l};
    lz       = 5'd0;
    lz_found = 1'b0;
    norm     = sum[26:0];
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = exp_n + 10'd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!lz_found && sum[i]) begin
          lz       = 5'(26 - i);
          lz_found = 1'b1;
        end
      end
      norm  = sum[26:0] << lz;
      exp_n = exp_n - {5'd0, lz};
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
    frac     = rnd[24] ? rnd[23:1] : rnd[22:0];
    if (rnd[24]) exp_n = exp_n + 10'd1;

    result    = {sign_l, exp_n[7:0], frac};
    exception = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      result    = 32'hFFFF_FFFF;
      exception = 1'b1;
    end else if (sum == 28'd0) begin
      result = 32'd0;
    end else if (!exp_n[9] && exp_n >= 10'd255) begin
      result   = {sign_l, 8'hFF, 23'd0};
      overflow = 1'b1;
    end else if (exp_n[9] || exp_n == 10'd0) begin
      result    = {sign_l, 31'd0};
      underflow = 1'b1;
    end
  end
endmodule

module fp_addsub_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_exc,
  output logic             rsp_ovf,
  output logic             rsp_unf,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_reg;
  logic             last_grant_reg, id_reg;
  logic [31:0]      opa_reg, opb_reg;
  logic             opsub_reg;
  logic             rsp_id_reg, rsp_exc_reg, rsp_ovf_reg, rsp_unf_reg;
  logic [31:0]      rsp_result_reg;
  logic [CNT_W-1:0] cnt_reg  [2];
  logic [CNT_W-1:0] cnt_next [2];

  logic        grant, grant_id, handshake;
  logic [31:0] core_result;
  logic        core_exc, core_ovf, core_unf;

  add_sub u_core (
    .a         (opa_reg),
    .b         (opb_reg),
    .sub       (opsub_reg),
    .result    (core_result),
    .exception (core_exc),
    .overflow  (core_ovf),
    .underflow (core_unf)
  );

  // When both ports request, the port that was not granted last time wins.
  // When only one port requests, that port wins.
  always_comb begin
    if (req0_valid && req1_valid) grant_id = ~last_grant_reg;
    else                          grant_id = req1_valid;
  end

  // rst gates the grant so no ready is visible during a reset cycle.
  assign grant      = !rst && (state_reg == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = grant && !grant_id;
  assign req1_ready = grant && grant_id;
  assign handshake  = (state_reg == RESP) && rsp_ready;

  // Saturating per-port counters; only the counter for rsp_id advances.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      assign cnt_next[gi] = (handshake && rsp_id_reg == 1'(gi) && cnt_reg[gi] != '1)
                            ? cnt_reg[gi] + CNT_W'(1) : cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      opa_reg        <= 32'd0;
      opb_reg        <= 32'd0;
      opsub_reg      <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= 32'd0;
      rsp_exc_reg    <= 1'b0;
      rsp_ovf_reg    <= 1'b0;
      rsp_unf_reg    <= 1'b0;
      cnt_reg[0]     <= '0;
      cnt_reg[1]     <= '0;
    end else begin
      cnt_reg[0] <= cnt_next[0];
      cnt_reg[1] <= cnt_next[1];
      case (state_reg)
        IDLE: begin
          if (grant) begin
            opa_reg        <= grant_id ? req1_a : req0_a;
            opb_reg        <= grant_id ? req1_b : req0_b;
            opsub_reg      <= grant_id ? req1_sub : req0_sub;
            id_reg         <= grant_id;
            last_grant_reg <= grant_id;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_reg <= core_result;
          rsp_exc_reg    <= core_exc;
          rsp_ovf_reg    <= core_ovf;
          rsp_unf_reg    <= core_unf;
          rsp_id_reg     <= id_reg;
          state_reg      <= RESP;
        end
        RESP: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = (state_reg == RESP);
  assign busy       = (state_reg != IDLE);
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_exc    = rsp_exc_reg;
  assign rsp_ovf    = rsp_ovf_reg;
  assign rsp_unf    = rsp_unf_reg;
  assign cnt0       = cnt_reg[0];
  assign cnt1       = cnt_reg[1];
endmodule

// File: doc/fp_addsub_arbiter.md
FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of each per-port completed-operation counter.
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_a  input  32  port 0 operand A, IEEE-754 single.
- req0_b  input  32  port 0 operand B.
- req0_sub  input  1  port 0 operation select: 0 add, 1 subtract.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same directions/widths  port 1 equivalents.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  1  port index of the response.
- rsp_result  output  32  result word.
- rsp_exc  output  1  exception flag.
- rsp_ovf  output  1  overflow flag.
- rsp_unf  output  1  underflow flag.
- busy  output  1  high whenever state is not IDLE.
- cnt0  output  CNT_W  completed port-0 operations.
- cnt1  output  CNT_W  completed port-1 operations.

Function
REQ-003 The block SHALL share one instance of the combinational FP add/sub core (add_sub) between the two ports. Its inputs SHALL be driven only from internal operand registers (opa, opb, opsub).
REQ-004 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-005 In IDLE, if any reqN_valid is high, the block SHALL grant exactly one port, assert only that port's reqN_ready combinationally in the same cycle, capture its a/b/sub into opa/opb/opsub and its index into id_q, and go to EXEC.
REQ-006 reqN_ready SHALL be low in every cycle where state is not IDLE, and SHALL never be high for both ports at once.
REQ-007 Arbitration SHALL be round-robin using a 1-bit last_grant register:
- Both valid: grant the port not equal to last_grant.
- Single valid: grant that port.
- last_grant SHALL update to the granted index on each grant.
REQ-008 In EXEC (exactly one cycle), the block SHALL register the core outputs Result, Exception, Overflow and Underflow into rsp_result/rsp_exc/rsp_ovf/rsp_unf, register id_q into rsp_id, and go to RESP.
REQ-009 In RESP, rsp_valid SHALL be high. All rsp_* outputs SHALL stay stable until the cycle with rsp_valid&&rsp_ready. On that cycle the FSM SHALL return to IDLE.
REQ-010 Latency: for a grant at edge N, rsp_valid SHALL first be high after edge N+2. Minimum issue interval is 3 cycles.
REQ-011 A new grant SHALL NOT occur in the same cycle the response handshake completes; the earliest next reqN_ready is the cycle after.
REQ-012 rsp_valid SHALL be low in IDLE and EXEC.
REQ-013 On each response handshake, cnt[rsp_id] SHALL increment by 1.
- Each counter SHALL saturate at 2^CNT_W-1 and not wrap.
- The other counter SHALL be unchanged.
REQ-014 A request deasserting valid before being granted SHALL be dropped without side effects. Requesters are not required to hold valid.
REQ-015 The block SHALL pass core flags through unmodified, with no reinterpretation of Exception, Overflow or Underflow.

Reset
REQ-016 When rst is high at a clock edge, the block SHALL set:
- state = IDLE, last_grant = 1 (so port 0 wins the first contested grant)
- rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_exc = rsp_ovf = rsp_unf = 0
- cnt0 = cnt1 = 0, busy = 0, opa = opb = 0, opsub = 0
REQ-017 Reset asserted during EXEC or RESP SHALL abandon the in-flight operation. No response and no counter increment SHALL result from it.
REQ-018 req0_ready and req1_ready SHALL be low during any cycle in which rst is high.

Verification
REQ-019 Single add: port 0 issues a=0x3FC00000 (1.5), b=0x40100000 (2.25), sub=0, with rsp_ready=1. Required: rsp_valid 2 cycles after grant, rsp_id=0, rsp_result=0x40700000 (3.75), flags 0, cnt0=1.
REQ-020 Contention: both ports valid continuously from reset release, rsp_ready=1. Required: grants alternate 0,1,0,1; port 0 a=0x40000000, b=0x3F800000, sub=1 yields 0x3F800000; cnt0=cnt1=2 after four responses.
REQ-021 Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Required: rsp_* stable and both readys low throughout; one handshake; counter +1 only.
REQ-022 Exception path: port 1 a=0x7F800000, b=0x3F800000. Required: rsp_exc=1, rsp_result=0xFFFFFFFF, rsp_id=1.
REQ-023 Reset mid-operation: assert rst in EXEC. Required: next cycle state IDLE, rsp_valid=0, counters 0; the following request completes normally.
REQ-024 Saturation with CNT_W=2: complete 5 port-0 operations. Required: cnt0=3, cnt1=0.
